cache_controller_2way_wt: RTL and testbench

Parametrised 2-way set-associative, write-through, no-write-allocate data cache sitting between the MEM stage and a generic single-word memory-side handshake (SRAM controller). It generalises address, data and index widths. Compared with the fixed-size predecessor, it adds:
- an explicit miss FSM
- a write-through path with write-hit update
- invalid-way-first victim selection
- a whole-cache invalidate operation
- saturating hit/miss counters

---
 rtl/cache_controller_2way_wt_if.sv | 35 +++
 rtl/cache_controller_2way_wt.sv | 198 +++++++++++++++++++
 tb/tb_cache_controller_2way_wt.sv | 388 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_controller_2way_wt_if.sv
// CPU-side and memory-side handshake bundle for the 2-way write-through cache.
// The slave modport is the cache's view; master is the CPU/memory environment.
interface cache_controller_2way_wt_if #(
   parameter int ADDR_W = 19,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
);
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_rd_en;
   logic              cpu_wr_en;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_ready;
   logic              flush;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_rd_en;
   logic              mem_wr_en;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;
   logic [CNT_W-1:0]  hit_count;
   logic [CNT_W-1:0]  miss_count;

   modport slave (
      input  cpu_addr, cpu_wdata, cpu_rd_en, cpu_wr_en, flush, mem_rdata, mem_ready,
      output cpu_rdata, cpu_ready, mem_addr, mem_wdata, mem_rd_en, mem_wr_en,
             hit_count, miss_count
   );

   modport master (
      output cpu_addr, cpu_wdata, cpu_rd_en, cpu_wr_en, flush, mem_rdata, mem_ready,
      input  cpu_rdata, cpu_ready, mem_addr, mem_wdata, mem_rd_en, mem_wr_en,
             hit_count, miss_count
   );
endinterface

// File: rtl/cache_controller_2way_wt.sv
// 2-way set-associative, write-through, no-write-allocate data cache with
// zero-latency read hits, invalid-first/LRU replacement and sequential flush.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | lookup on cpu_addr; read hits complete combinationally
// ST_RD_MISS | line fetch outstanding, fill victim on mem_ready
// ST_WR_THRU | memory write outstanding, update hit way on mem_ready
// ST_FLUSH   | clearing valid/lru one set per cycle
module cache_controller_2way_wt #(
   parameter int ADDR_W   = 19,
   parameter int DATA_W   = 32,
   parameter int INDEX_W  = 6,
   parameter int OFFSET_W = 2,
   parameter int CNT_W    = 16
) (
   input logic clk,
   input logic rst,
   cache_controller_2way_wt_if.slave bus
);
   localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
   localparam int SETS  = 1 << INDEX_W;

   typedef enum logic [1:0] {ST_IDLE, ST_RD_MISS, ST_WR_THRU, ST_FLUSH} state_e;

   state_e state_q, state_d;

   logic [SETS-1:0]    vld0_q, vld1_q, lru_q;
   logic [TAG_W-1:0]   tag0_q  [SETS];
   logic [TAG_W-1:0]   tag1_q  [SETS];
   logic [DATA_W-1:0]  data0_q [SETS];
   logic [DATA_W-1:0]  data1_q [SETS];

   logic [ADDR_W-1:0]  mem_addr_q;
   logic [DATA_W-1:0]  mem_wdata_q;
   logic               mem_rd_en_q, mem_wr_en_q;
   logic [INDEX_W-1:0] flush_idx_q;
   logic [CNT_W-1:0]   hit_cnt_q, miss_cnt_q;

   logic [TAG_W-1:0]   lk_tag;
   logic [INDEX_W-1:0] lk_idx;
   logic               hit0, hit1, hit_any, victim;
   logic               rd_req, wr_req;

   logic               cpu_ready;
   logic [DATA_W-1:0]  cpu_rdata;
   logic               rd_hit, rd_miss_go, wr_go, fill_en, wr_done, flush_clr;

   assign rd_req = bus.cpu_rd_en;
   assign wr_req = bus.cpu_wr_en & ~bus.cpu_rd_en;

   // Outside IDLE the lookup follows the latched request address.
   always_comb begin
      if (state_q == ST_IDLE) begin
         lk_tag = bus.cpu_addr[ADDR_W-1 -: TAG_W];
         lk_idx = bus.cpu_addr[OFFSET_W +: INDEX_W];
      end else begin
         lk_tag = mem_addr_q[ADDR_W-1 -: TAG_W];
         lk_idx = mem_addr_q[OFFSET_W +: INDEX_W];
      end
   end

   assign hit0    = vld0_q[lk_idx] && (tag0_q[lk_idx] == lk_tag);
   assign hit1    = vld1_q[lk_idx] && (tag1_q[lk_idx] == lk_tag);
   assign hit_any = hit0 | hit1;
   assign victim  = !vld0_q[lk_idx] ? 1'b0 :
                    !vld1_q[lk_idx] ? 1'b1 : lru_q[lk_idx];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.flush)                state_d = ST_FLUSH;
            else if (rd_req && !hit_any)  state_d = ST_RD_MISS;
            else if (wr_req)              state_d = ST_WR_THRU;
         end
         ST_RD_MISS, ST_WR_THRU: if (bus.mem_ready) state_d = ST_IDLE;
         ST_FLUSH:               if (&flush_idx_q)  state_d = ST_IDLE;
         default:                state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cpu_ready  = 1'b0;
      cpu_rdata  = hit1 ? data1_q[lk_idx] : data0_q[lk_idx];
      rd_hit     = 1'b0;
      rd_miss_go = 1'b0;
      wr_go      = 1'b0;
      fill_en    = 1'b0;
      wr_done    = 1'b0;
      flush_clr  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.flush) begin
               flush_clr = 1'b1;
            end else if (rd_req) begin
               cpu_ready  = hit_any;
               rd_hit     = hit_any;
               rd_miss_go = !hit_any;
            end else if (wr_req) begin
               wr_go = 1'b1;
            end else begin
               cpu_ready = 1'b1;
            end
         end
         ST_RD_MISS: begin
            cpu_ready = bus.mem_ready;
            cpu_rdata = bus.mem_rdata;
            fill_en   = bus.mem_ready;
         end
         ST_WR_THRU: begin
            cpu_ready = bus.mem_ready;
            wr_done   = bus.mem_ready;
         end
         ST_FLUSH: flush_clr = 1'b1;
         default: ;
      endcase
   end

   // The flush index sits at 0 in IDLE, so the accepting cycle clears set 0
   // and FLUSH walks the rest, wrapping the index back to 0 on exit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld0_q      <= '0;
         vld1_q      <= '0;
         lru_q       <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_rd_en_q <= 1'b0;
         mem_wr_en_q <= 1'b0;
         flush_idx_q <= '0;
         hit_cnt_q   <= '0;
         miss_cnt_q  <= '0;
      end else begin
         if (rd_miss_go) begin
            mem_addr_q  <= bus.cpu_addr;
            mem_rd_en_q <= 1'b1;
            if (!(&miss_cnt_q)) miss_cnt_q <= miss_cnt_q + 1'b1;
         end
         if (wr_go) begin
            mem_addr_q  <= bus.cpu_addr;
            mem_wdata_q <= bus.cpu_wdata;
            mem_wr_en_q <= 1'b1;
         end
         if (fill_en) begin
            mem_rd_en_q <= 1'b0;
            if (victim) vld1_q[lk_idx] <= 1'b1;
            else        vld0_q[lk_idx] <= 1'b1;
            lru_q[lk_idx] <= ~victim;
         end
         if (wr_done) begin
            mem_wr_en_q <= 1'b0;
            if (hit_any) lru_q[lk_idx] <= ~hit1;
         end
         if (rd_hit) begin
            lru_q[lk_idx] <= ~hit1;
            if (!(&hit_cnt_q)) hit_cnt_q <= hit_cnt_q + 1'b1;
         end
         if (flush_clr) begin
            vld0_q[flush_idx_q] <= 1'b0;
            vld1_q[flush_idx_q] <= 1'b0;
            lru_q[flush_idx_q]  <= 1'b0;
            flush_idx_q         <= flush_idx_q + 1'b1;
         end
      end
   end

   // Tag/data storage is qualified by the valid bits and needs no reset.
   always_ff @(posedge clk) begin
      if (fill_en) begin
         if (victim) begin
            tag1_q[lk_idx]  <= lk_tag;
            data1_q[lk_idx] <= bus.mem_rdata;
         end else begin
            tag0_q[lk_idx]  <= lk_tag;
            data0_q[lk_idx] <= bus.mem_rdata;
         end
      end
      if (wr_done && hit_any) begin
         if (hit1) data1_q[lk_idx] <= mem_wdata_q;
         else      data0_q[lk_idx] <= mem_wdata_q;
      end
   end

   assign bus.cpu_ready  = cpu_ready;
   assign bus.cpu_rdata  = cpu_rdata;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.mem_rd_en  = mem_rd_en_q;
   assign bus.mem_wr_en  = mem_wr_en_q;
   assign bus.hit_count  = hit_cnt_q;
   assign bus.miss_count = miss_cnt_q;
endmodule

// File: tb/tb_cache_controller_2way_wt.sv
// Bench for cache_controller_2way_wt: directed vector table, hand sequences for
// flush/reset/saturation, and random traffic against a recency-list model.
module tb_cache_controller_2way_wt;
   logic clk;
   logic rst;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   cache_controller_2way_wt_if #(.ADDR_W(19), .DATA_W(32), .CNT_W(16)) bus ();
   cache_controller_2way_wt_if #(.ADDR_W(19), .DATA_W(32), .CNT_W(4))  bus_s ();

   cache_controller_2way_wt #(.ADDR_W(19), .DATA_W(32), .INDEX_W(6), .OFFSET_W(2), .CNT_W(16))
      dut (.clk(clk), .rst(rst), .bus(bus));

   cache_controller_2way_wt #(.ADDR_W(19), .DATA_W(32), .INDEX_W(6), .OFFSET_W(2), .CNT_W(4))
      dut_s (.clk(clk), .rst(rst), .bus(bus_s));

   int n_cmp = 0;
   int n_err = 0;
   int lat   = 1;
   int rsp_cnt = 0;

   logic [31:0] phys_mem [int];
   logic [31:0] ref_mem  [int];

   // Reference cache: per set, resident tags ordered most-recent first.
   int unsigned m_set [64][$];
   int unsigned m_hits, m_misses;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] init_word(int a);
      return 32'h5A00_0000 | a;
   endfunction

   function automatic logic [31:0] phys_rd(int a);
      return phys_mem.exists(a) ? phys_mem[a] : init_word(a);
   endfunction

   function automatic logic [31:0] ref_rd(int a);
      return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
   endfunction

   function automatic bit model_read(int unsigned a);
      int unsigned s = (a >> 2) & 63;
      int unsigned t = a >> 8;
      for (int i = 0; i < m_set[s].size(); i++) begin
         if (m_set[s][i] == t) begin
            m_set[s].delete(i);
            m_set[s].push_front(t);
            if (m_hits < 65535) m_hits++;
            return 1'b1;
         end
      end
      m_set[s].push_front(t);
      if (m_set[s].size() > 2) void'(m_set[s].pop_back());
      if (m_misses < 65535) m_misses++;
      return 1'b0;
   endfunction

   function automatic void model_write(int unsigned a, logic [31:0] d);
      int unsigned s = (a >> 2) & 63;
      int unsigned t = a >> 8;
      ref_mem[int'(a)] = d;
      for (int i = 0; i < m_set[s].size(); i++) begin
         if (m_set[s][i] == t) begin
            m_set[s].delete(i);
            m_set[s].push_front(t);
            break;
         end
      end
   endfunction

   function automatic void model_flush();
      for (int s = 0; s < 64; s++) m_set[s].delete();
   endfunction

   // Memory responder: mem_ready pulses 'lat' cycles after the request appears.
   initial begin
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(posedge clk); #1;
         if (rst) begin
            rsp_cnt = 0;
            bus.mem_ready = 1'b0;
         end else if (bus.mem_ready) begin
            bus.mem_ready = 1'b0;
         end else if (bus.mem_rd_en || bus.mem_wr_en) begin
            rsp_cnt++;
            if (rsp_cnt >= lat) begin
               rsp_cnt = 0;
               bus.mem_ready = 1'b1;
               if (bus.mem_rd_en) bus.mem_rdata = phys_rd(int'(bus.mem_addr));
               else               phys_mem[int'(bus.mem_addr)] = bus.mem_wdata;
            end
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic do_reset();
      rst = 1'b1;
      bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_rd_en = 1'b0; bus.cpu_wr_en = 1'b0;
      bus.flush = 1'b0;
      bus_s.cpu_addr = '0; bus_s.cpu_wdata = '0; bus_s.cpu_rd_en = 1'b0; bus_s.cpu_wr_en = 1'b0;
      bus_s.flush = 1'b0; bus_s.mem_ready = 1'b0; bus_s.mem_rdata = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      model_flush();
      m_hits = 0;
      m_misses = 0;
   endtask

   task automatic do_read(input logic [18:0] a, output bit hit_seen, output logic [31:0] rdata,
                          output int rd_cycles, output bit mr);
      int  n = 0;
      bit  done = 0;
      hit_seen = 0; rdata = '0; rd_cycles = 0; mr = 0;
      bus.cpu_addr = a;
      bus.cpu_rd_en = 1'b1;
      while (!done && n < 200) begin
         @(negedge clk);
         if (bus.mem_rd_en) begin
            rd_cycles++;
            if (rd_cycles == 1) chk("rd_mem_addr", bus.mem_addr, a);
         end
         if (bus.cpu_ready) begin
            done = 1;
            hit_seen = (n == 0);
            rdata = bus.cpu_rdata;
            mr = bus.mem_ready;
         end
         n++;
      end
      chk("rd_done", done, 1);
      @(posedge clk); #1;
      bus.cpu_rd_en = 1'b0;
   endtask

   task automatic do_write(input logic [18:0] a, input logic [31:0] d,
                           output bit wr_seen, output bit fast);
      int n = 0;
      bit done = 0;
      wr_seen = 0; fast = 0;
      bus.cpu_addr = a;
      bus.cpu_wdata = d;
      bus.cpu_wr_en = 1'b1;
      while (!done && n < 200) begin
         @(negedge clk);
         if (bus.mem_wr_en && !wr_seen) begin
            wr_seen = 1;
            chk("wr_mem_addr", bus.mem_addr, a);
            chk("wr_mem_wdata", bus.mem_wdata, d);
         end
         if (bus.cpu_ready) begin
            done = 1;
            fast = (n == 0);
         end
         n++;
      end
      chk("wr_done", done, 1);
      @(posedge clk); #1;
      bus.cpu_wr_en = 1'b0;
   endtask

   typedef struct {
      bit          wr;
      logic [18:0] addr;
      logic [31:0] wdata;
      bit          exp_hit;
      int          exp_hits;
      int          exp_misses;
   } vec_t;

   vec_t tbl [13];

   initial begin
      bit          hs, mr, ws, fast, seen;
      logic [31:0] rd;
      int          rc, n_low, n_rdy;
      logic [18:0] a;
      logic [31:0] d;
      int          op;
      bit          eh;

      tbl[0]  = '{0, 19'h00100, 32'h0,        0, 0, 1};
      tbl[1]  = '{0, 19'h00200, 32'h0,        0, 0, 2};
      tbl[2]  = '{0, 19'h00100, 32'h0,        1, 1, 2};
      tbl[3]  = '{0, 19'h00300, 32'h0,        0, 1, 3};
      tbl[4]  = '{0, 19'h00100, 32'h0,        1, 2, 3};
      tbl[5]  = '{0, 19'h00200, 32'h0,        0, 2, 4};
      tbl[6]  = '{1, 19'h00100, 32'h12345678, 1, 2, 4};
      tbl[7]  = '{0, 19'h00100, 32'h0,        1, 3, 4};
      tbl[8]  = '{1, 19'h00400, 32'hCAFEF00D, 0, 3, 4};
      tbl[9]  = '{0, 19'h00400, 32'h0,        0, 3, 5};
      tbl[10] = '{0, 19'h00100, 32'h0,        1, 4, 5};
      tbl[11] = '{0, 19'h00300, 32'h0,        0, 4, 6};
      tbl[12] = '{0, 19'h00100, 32'h0,        1, 5, 6};

      do_reset();
      chk("rst_cpu_ready",  bus.cpu_ready, 1);
      chk("rst_mem_rd_en",  bus.mem_rd_en, 0);
      chk("rst_mem_wr_en",  bus.mem_wr_en, 0);
      chk("rst_mem_addr",   bus.mem_addr, 0);
      chk("rst_mem_wdata",  bus.mem_wdata, 0);
      chk("rst_hit_count",  bus.hit_count, 0);
      chk("rst_miss_count", bus.miss_count, 0);

      // Miss with 3-cycle memory latency, then a zero-latency hit.
      lat = 3;
      phys_mem[32'h100] = 32'hDEADBEEF;
      ref_mem[32'h100]  = 32'hDEADBEEF;
      eh = model_read(32'h100);
      do_read(19'h00100, hs, rd, rc, mr);
      chk("t1_hit", hs, eh);
      chk("t1_rd_cycles", rc, 3);
      chk("t1_ready_with_mem_ready", mr, 1);
      chk("t1_rdata", rd, 32'hDEADBEEF);
      chk("t1_miss_count", bus.miss_count, 1);
      eh = model_read(32'h100);
      do_read(19'h00100, hs, rd, rc, mr);
      chk("t1_rehit", hs, eh);
      chk("t1_rehit_no_mem", rc, 0);
      chk("t1_rehit_rdata", rd, 32'hDEADBEEF);
      chk("t1_hit_count", bus.hit_count, 1);

      // Directed LRU / write-through table.
      do_reset();
      phys_mem.delete();
      ref_mem.delete();
      lat = 2;
      for (int i = 0; i < 13; i++) begin
         if (tbl[i].wr) begin
            model_write(int'(tbl[i].addr), tbl[i].wdata);
            do_write(tbl[i].addr, tbl[i].wdata, ws, fast);
            chk("tbl_wr_seen", ws, 1);
            chk("tbl_wr_not_fast", fast, 0);
         end else begin
            void'(model_read(int'(tbl[i].addr)));
            do_read(tbl[i].addr, hs, rd, rc, mr);
            chk("tbl_hit", hs, tbl[i].exp_hit);
            chk("tbl_rdata", rd, ref_rd(int'(tbl[i].addr)));
         end
         chk("tbl_hit_count", bus.hit_count, tbl[i].exp_hits);
         chk("tbl_miss_count", bus.miss_count, tbl[i].exp_misses);
      end

      // Flush with a same-cycle read to a cached line: 64 flush cycles plus
      // the miss-detect cycle before the fetch shows up.
      do_reset();
      lat = 1;
      void'(model_read(32'h100));
      do_read(19'h00100, hs, rd, rc, mr);
      chk("t4_fill_miss", hs, 0);
      bus.cpu_addr = 19'h00100;
      bus.cpu_rd_en = 1'b1;
      bus.flush = 1'b1;
      @(negedge clk);
      chk("t4_ready_flush_cycle", bus.cpu_ready, 0);
      n_low = 1; n_rdy = 0; seen = 0;
      @(posedge clk); #1 bus.flush = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (bus.mem_rd_en) seen = 1;
         else begin
            n_low++;
            if (bus.cpu_ready) n_rdy++;
         end
      end
      chk("t4_rd_issued", seen, 1);
      chk("t4_low_cycles", n_low, 65);
      chk("t4_ready_during_flush", n_rdy, 0);
      chk("t4_ready_after", bus.cpu_ready, 1);
      chk("t4_rdata", bus.cpu_rdata, ref_rd(32'h100));
      @(posedge clk); #1 bus.cpu_rd_en = 1'b0;
      model_flush();
      void'(model_read(32'h100));
      chk("t4_miss_count", bus.miss_count, m_misses);

      // Asynchronous reset while a fetch is outstanding.
      do_reset();
      lat = 6;
      bus.cpu_addr = 19'h00200;
      bus.cpu_rd_en = 1'b1;
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         seen = bus.mem_rd_en;
      end
      chk("t5_rd_en_before_rst", seen, 1);
      chk("t5_miss_before_rst", bus.miss_count, 1);
      #2 rst = 1'b1;
      #1;
      chk("t5_rd_en_cleared", bus.mem_rd_en, 0);
      chk("t5_miss_cleared", bus.miss_count, 0);
      chk("t5_mem_addr_cleared", bus.mem_addr, 0);
      bus.cpu_rd_en = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1 rst = 1'b0;
      model_flush();
      m_hits = 0; m_misses = 0;
      lat = 2;
      do_read(19'h00100, hs, rd, rc, mr);
      chk("t5_read_misses", hs, 0);
      chk("t5_rd_cycles", rc, 2);
      chk("t5_miss_count", bus.miss_count, 1);

      // Saturating 4-bit hit counter on the second instance.
      bus_s.cpu_addr = 19'h00100;
      bus_s.cpu_rd_en = 1'b1;
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         seen = bus_s.mem_rd_en;
      end
      chk("t6_fetch", seen, 1);
      @(posedge clk); #1;
      bus_s.mem_ready = 1'b1;
      bus_s.mem_rdata = 32'hCAFE0001;
      @(negedge clk);
      chk("t6_fill_ready", bus_s.cpu_ready, 1);
      @(posedge clk); #1 bus_s.mem_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("t6_hit_ready", bus_s.cpu_ready, 1);
         chk("t6_hit_rdata", bus_s.cpu_rdata, 32'hCAFE0001);
         chk("t6_hit_count", bus_s.hit_count, (i < 15) ? i : 15);
      end
      @(posedge clk); #1 bus_s.cpu_rd_en = 1'b0;
      @(negedge clk);
      chk("t6_hit_count_sat", bus_s.hit_count, 15);
      chk("t6_miss_count", bus_s.miss_count, 1);
      @(posedge clk); #1;

      // Random traffic over 4 sets x 4 tags against the reference model.
      do_reset();
      for (int k = 0; k < 250; k++) begin
         op  = $urandom_range(0, 19);
         a   = 19'(($urandom_range(1, 4) << 8) | ($urandom_range(0, 3) << 2));
         lat = $urandom_range(1, 4);
         if (op < 2) begin
            bus.flush = 1'b1;
            @(negedge clk);
            chk("rnd_flush_ready_low", bus.cpu_ready, 0);
            @(posedge clk); #1 bus.flush = 1'b0;
            seen = 0;
            for (int i = 0; i < 100 && !seen; i++) begin
               @(negedge clk);
               seen = bus.cpu_ready;
            end
            chk("rnd_flush_done", seen, 1);
            @(posedge clk); #1;
            model_flush();
         end else if (op < 8) begin
            d = $urandom;
            model_write(int'(a), d);
            do_write(a, d, ws, fast);
            chk("rnd_wr_seen", ws, 1);
         end else begin
            eh = model_read(int'(a));
            do_read(a, hs, rd, rc, mr);
            chk("rnd_hit", hs, eh);
            chk("rnd_rd_cycles", rc, eh ? 0 : lat);
            chk("rnd_rdata", rd, ref_rd(int'(a)));
         end
         chk("rnd_hit_count", bus.hit_count, m_hits);
         chk("rnd_miss_count", bus.miss_count, m_misses);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
